// File: rtl/i2c_eeprom_slave.sv
// I2C target exposing a 2**ADDR_W byte register file with a byte pointer; reads and writes go through the pointer.
// Define I2C_SLAVE_AUTOINC_EN to advance the pointer after each written byte and each master-ACKed read byte.
module i2c_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR = 7'b1010000,
    parameter int          ADDR_W   = 4,
    parameter logic [7:0]  MEM_INIT = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl,
    inout  wire               sda,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);
`ifdef I2C_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam int DEPTH = 1 << ADDR_W;

    // state     | meaning
    // IDLE      | bus free or not ours, wait for START
    // DEV       | shifting in device address + R/W
    // DEV_ACK   | ACK for address byte, then branch on R/W
    // REG       | shifting in register pointer
    // REG_ACK   | ACK for pointer byte
    // WDATA     | shifting in a write data byte
    // WDATA_ACK | ACK for write data byte
    // RDATA     | shifting out mem[ptr]
    // RDATA_ACK | sampling master ACK/NACK
    // WAIT_STOP | ignore traffic until STOP or START
    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    logic              scl_s1, scl_s2, scl_d;
    logic              sda_s1, sda_s2, sda_d;
    logic [2:0]        arm;
    logic              live, scl_rise, scl_fall, start_det, stop_det;
    state_t            state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift;
    logic [7:0]        byte_in;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              ack_on;
    logic              sda_oe;
    logic [7:0]        mem [DEPTH];

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
            arm    <= '0;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
            arm    <= {arm[1:0], 1'b1};
        end
    end

    // Edges are ignored until the reset value of 1 has flushed out of every
    // flop; otherwise leaving reset mid-transfer could fake a START.
    assign live      = arm[2];
    assign scl_rise  = live & scl_s2 & ~scl_d;
    assign scl_fall  = live & ~scl_s2 & scl_d;
    assign start_det = live & scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = live & scl_s2 & scl_d & ~sda_d & sda_s2;
    assign byte_in   = {shift[6:0], sda_s2};
    assign ptr_nxt   = AUTOINC ? ptr + ADDR_W'(1) : ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            ptr       <= '0;
            ack_on    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= MEM_INIT;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state   <= DEV;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
            end else begin
                case (state)
                    DEV: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            busy  <= (byte_in[7:1] == DEV_ADDR);
                            state <= (byte_in[7:1] == DEV_ADDR) ? DEV_ACK : WAIT_STOP;
                        end
                    end
                    DEV_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe <= 1'b1;
                            ack_on <= 1'b1;
                        end else begin
                            ack_on  <= 1'b0;
                            bit_cnt <= '0;
                            if (shift[0]) begin
                                state  <= RDATA;
                                shift  <= {mem[ptr][6:0], 1'b0};
                                sda_oe <= ~mem[ptr][7];
                            end else begin
                                state  <= REG;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    REG_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe <= 1'b1;
                            ack_on <= 1'b1;
                        end else begin
                            sda_oe  <= 1'b0;
                            ack_on  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WDATA;
                        end
                    end
                    REG: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            ptr   <= byte_in[ADDR_W-1:0];
                            state <= REG_ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            mem[ptr]  <= byte_in;
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= byte_in;
                            ptr       <= ptr_nxt;
                            state     <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= RDATA_ACK;
                            end else begin
                                sda_oe <= ~shift[7];
                                shift  <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: if (scl_rise) begin
                        if (!sda_s2) begin
                            ptr     <= ptr_nxt;
                            shift   <= mem[ptr_nxt];
                            bit_cnt <= '0;
                            state   <= RDATA;
                        end else begin
                            state <= WAIT_STOP;
                        end
                    end
                    IDLE, WAIT_STOP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
